// File: rtl/cont_pkg.sv
// Shared counter definitions: end-mode constants and next-count helpers that
// the counter and later timer blocks reuse.
package cont_pkg;

  localparam int CONT_WRAP  = 0;
  localparam int CONT_SAT   = 1;
  localparam int CONT_MAX_W = 32;

  // One bit wider than the widest counter so MODULO = 2^WIDTH is representable.
  typedef logic [CONT_MAX_W:0] cont_wide_t;

  function automatic cont_wide_t contNext(input cont_wide_t q, input logic up,
                                          input cont_wide_t modulo, input logic sat);
    cont_wide_t last;
    last = modulo - cont_wide_t'(1);
    if (up) begin
      if (q < last) return q + cont_wide_t'(1);
      else if (sat) return q;
      else return '0;
    end else begin
      if (q != '0) return q - cont_wide_t'(1);
      else if (sat) return q;
      else return last;
    end
  endfunction

  function automatic logic contWraps(input cont_wide_t q, input logic up,
                                     input cont_wide_t modulo, input logic sat);
    cont_wide_t last;
    last = modulo - cont_wide_t'(1);
    return !sat && (up ? (q == last) : (q == '0));
  endfunction

endpackage

// File: rtl/cont_sinc_param.sv
// Parametrised up/down counter with load, enable and wrap-or-saturate end mode,
// a combinational terminal count for cascading and a registered wrap pulse.
module cont_sinc_param
  import cont_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16,
  parameter int INIT   = 0,
  parameter int SAT    = CONT_WRAP
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > CONT_MAX_W) begin : gBadWidth
    $error("cont_sinc_param: WIDTH must be in 1..%0d", CONT_MAX_W);
  end
  if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : gBadModulo
    $error("cont_sinc_param: MODULO must satisfy 2 <= MODULO <= 2^WIDTH");
  end
  if (INIT < 0 || INIT >= MODULO) begin : gBadInit
    $error("cont_sinc_param: INIT must be below MODULO");
  end
  if (SAT != CONT_WRAP && SAT != CONT_SAT) begin : gBadSat
    $error("cont_sinc_param: SAT must be 0 (wrap) or 1 (saturate)");
  end

  localparam logic [WIDTH-1:0] LAST     = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] INIT_V   = WIDTH'(INIT);
  localparam logic [WIDTH:0]   MOD_W    = (WIDTH + 1)'(MODULO);
  localparam cont_wide_t       MOD_WIDE = cont_wide_t'(MODULO);
  localparam logic             SAT_B    = (SAT == CONT_SAT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  // Load beats counting and always clears the wrap pulse; out-of-range load
  // values clamp to the last legal count.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = ({1'b0, D} < MOD_W) ? D : LAST;
    end else if (en) begin
      count_d = WIDTH'(contNext(cont_wide_t'(count_q), up, MOD_WIDE, SAT_B));
      wrap_d  = contWraps(cont_wide_t'(count_q), up, MOD_WIDE, SAT_B);
    end
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      count_q <= INIT_V;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Q    = count_q;
  assign wrap = wrap_q;
  assign tc   = en & (up ? (count_q == LAST) : (count_q == '0));

endmodule

// File: tb/tb_cont_sinc_param.sv
// Scoreboard bench for cont_sinc_param: a wrapping decade counter, a saturating
// decade counter and a two-stage hex cascade, checked against plain arithmetic.
module tb_cont_sinc_param;

  logic clk = 1'b0;
  logic CLR = 1'b0;

  logic       enA = 1'b0, upA = 1'b0, loadA = 1'b0;
  logic [3:0] dA = '0, qA;
  logic       tcA, wrapA;

  logic       enB = 1'b0, upB = 1'b0, loadB = 1'b0;
  logic [3:0] dB = '0, qB;
  logic       tcB, wrapB;

  logic       enC = 1'b0, upC = 1'b0, loadC = 1'b0;
  logic [7:0] dC = '0;
  logic [3:0] q1, q2;
  logic       tc1, tc2, wrap1, wrap2;

  always #5 clk = ~clk;

  cont_sinc_param #(.WIDTH(4), .MODULO(10), .INIT(3), .SAT(0)) dutA (
    .clk(clk), .CLR(CLR), .en(enA), .up(upA), .load(loadA), .D(dA),
    .Q(qA), .tc(tcA), .wrap(wrapA));

  cont_sinc_param #(.WIDTH(4), .MODULO(10), .INIT(0), .SAT(1)) dutB (
    .clk(clk), .CLR(CLR), .en(enB), .up(upB), .load(loadB), .D(dB),
    .Q(qB), .tc(tcB), .wrap(wrapB));

  cont_sinc_param #(.WIDTH(4), .MODULO(16), .INIT(0), .SAT(0)) dutC1 (
    .clk(clk), .CLR(CLR), .en(enC), .up(upC), .load(loadC), .D(dC[3:0]),
    .Q(q1), .tc(tc1), .wrap(wrap1));

  cont_sinc_param #(.WIDTH(4), .MODULO(16), .INIT(0), .SAT(0)) dutC2 (
    .clk(clk), .CLR(CLR), .en(tc1), .up(upC), .load(loadC), .D(dC[7:4]),
    .Q(q2), .tc(tc2), .wrap(wrap2));

  int checks   = 0;
  int failures = 0;

  // Reference state: A and B counts, C as the whole 8-bit cascade value.
  int mA = 3;
  int mB = 0;
  int mC = 0;

  typedef struct {
    int id;
    int q;
    bit w;
    bit t;
  } exp_t;

  exp_t sbQ[$];

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Behavioural next count straight from the counting rules, using modular arithmetic.
  function automatic void refNext(input int q, input int modulo, input bit sat,
                                  input bit ld, input int d, input bit e, input bit u,
                                  output int nq, output bit w);
    nq = q;
    w  = 1'b0;
    if (ld) begin
      nq = (d < modulo) ? d : modulo - 1;
    end else if (e) begin
      if (sat) begin
        nq = u ? ((q + 1 > modulo - 1) ? modulo - 1 : q + 1)
               : ((q - 1 < 0) ? 0 : q - 1);
      end else begin
        nq = u ? (q + 1) % modulo : (q + modulo - 1) % modulo;
        w  = u ? (nq == 0) : (q == 0);
      end
    end
  endfunction

  task automatic applyStimulus(input bit eA, input bit uA, input bit lA, input int dAv,
                               input bit eB, input bit uB, input bit lB, input int dBv,
                               input bit eC, input bit uC, input bit lC, input int dCv);
    int   nq;
    bit   w;
    exp_t e;
    @(negedge clk);
    #1;
    enA = eA; upA = uA; loadA = lA; dA = 4'(dAv);
    enB = eB; upB = uB; loadB = lB; dB = 4'(dBv);
    enC = eC; upC = uC; loadC = lC; dC = 8'(dCv);

    refNext(mA, 10, 1'b0, lA, dAv, eA, uA, nq, w);
    mA = nq;
    e.id = 0; e.q = mA; e.w = w; e.t = eA && (uA ? (mA == 9) : (mA == 0));
    sbQ.push_back(e);

    refNext(mB, 10, 1'b1, lB, dBv, eB, uB, nq, w);
    mB = nq;
    e.id = 1; e.q = mB; e.w = w; e.t = eB && (uB ? (mB == 9) : (mB == 0));
    sbQ.push_back(e);

    w = 1'b0;
    if (lC) begin
      mC = dCv;
    end else if (eC) begin
      w  = uC ? (mC == 255) : (mC == 0);
      mC = uC ? (mC + 1) % 256 : (mC + 255) % 256;
    end
    e.id = 2; e.q = mC; e.w = w; e.t = eC && (uC ? (mC == 255) : (mC == 0));
    sbQ.push_back(e);
  endtask

  // Monitor: each falling edge the outputs of the preceding rising edge are ready.
  exp_t  it;
  int    gq;
  bit    gw, gt;
  string nm;
  initial begin
    forever begin
      @(negedge clk);
      while (sbQ.size() > 0) begin
        it = sbQ.pop_front();
        case (it.id)
          0:       begin nm = "A"; gq = int'(qA);       gw = wrapA; gt = tcA; end
          1:       begin nm = "B"; gq = int'(qB);       gw = wrapB; gt = tcB; end
          default: begin nm = "C"; gq = int'({q2, q1}); gw = wrap2; gt = tc2; end
        endcase
        checkOutput($sformatf("%s.q@%0t", nm, $time), gq, it.q);
        checkOutput($sformatf("%s.wrap@%0t", nm, $time), int'(gw), int'(it.w));
        checkOutput($sformatf("%s.tc@%0t", nm, $time), int'(gt), int'(it.t));
      end
    end
  end

  initial begin
    #1 CLR = 1'b1;
    #9;
    checkOutput("rst.hold.A.q", int'(qA), 3);
    checkOutput("rst.hold.A.wrap", int'(wrapA), 0);
    #11 CLR = 1'b0;
    #2;
    checkOutput("rst.A.q", int'(qA), 3);
    checkOutput("rst.A.wrap", int'(wrapA), 0);
    checkOutput("rst.A.tc", int'(tcA), 0);
    checkOutput("rst.B.q", int'(qB), 0);
    checkOutput("rst.C.q", int'({q2, q1}), 0);

    // Up-wrap on A, down-saturate on B, full-range cascade on C.
    applyStimulus(0, 1, 1, 0,  0, 0, 1, 2,  0, 1, 1, 0);
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 1, 0, 0,  (i < 4), 0, 0, 0,  1, 1, 0, 0);
    applyStimulus(1, 1, 1, 13,  0, 0, 0, 0,  1, 1, 0, 0);
    applyStimulus(1, 1, 1, 5,   0, 0, 0, 0,  1, 1, 0, 0);
    for (int i = 0; i < 242; i++)
      applyStimulus(0, 1, 0, 0,  0, 0, 0, 0,  1, 1, 0, 0);

    // Park A at 7, then clear asynchronously shortly after an edge.
    applyStimulus(0, 1, 1, 7,  0, 0, 0, 0,  0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0,  0, 0, 0, 0,  0, 1, 0, 0);
    @(negedge clk);
    #2;
    @(posedge clk);
    #3;
    checkOutput("clr.pre.A.q", int'(qA), 7);
    CLR = 1'b1;
    #1;
    checkOutput("clr.A.q", int'(qA), 3);
    checkOutput("clr.A.wrap", int'(wrapA), 0);
    checkOutput("clr.B.q", int'(qB), 0);
    checkOutput("clr.C.q", int'({q2, q1}), 0);
    mA = 3;
    mB = 0;
    mC = 0;
    @(negedge clk);
    #1 CLR = 1'b0;

    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0), int'($urandom_range(0, 255)));

    @(negedge clk);
    #2;
    checkOutput("sb.drain", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cont_sinc_param.md
# cont_sinc_param

Parametrised synchronous counter, successor to the fixed 4-bit 0–15 up-counter with preset/clear. Adds configurable width and modulus, an up/down direction, a synchronous parallel load, a count enable, and a wrap-or-saturate end mode. It provides a combinational terminal-count output for cascading stages and a registered one-cycle wrap pulse. It is the standard counter for the practical-lab designs: dividers, timers, and cascaded decade counters.

## Interface
- WIDTH, 4 — counter width in bits; must be ≥1.
- MODULO, 16 — count range 0..MODULO-1; must satisfy 2 ≤ MODULO ≤ 2^WIDTH.
- INIT, 0 — value forced onto Q by reset; must be < MODULO.
- SAT, 0 — end mode: 0 = wrap around, 1 = saturate (hold at the end value).
- clk  in  1 — the single clock; all state changes on its rising edge.
- CLR  in  1 — reset, asynchronous, active-high.
- en  in  1 — count enable.
- up  in  1 — direction: 1 = count up, 0 = count down.
- load  in  1 — synchronous parallel load.
- D  in  WIDTH — load value.
- Q  out  WIDTH — current count.
- tc  out  1 — terminal count (combinational).
- wrap  out  1 — registered pulse, one cycle wide.

## Operation
- Priority order: CLR, then load, then en, then hold.
- CLR high: Q = INIT and wrap = 0 immediately, independent of clk; both hold while CLR stays high.
- load = 1 at an edge: Q ← D when D < MODULO, otherwise Q ← MODULO-1. load ignores en. wrap ← 0.
- en = 1, load = 0, counting up:
  - Q < MODULO-1: Q ← Q+1.
  - Q = MODULO-1, SAT = 0: Q ← 0 and wrap ← 1.
  - Q = MODULO-1, SAT = 1: Q holds and wrap ← 0.
- en = 1, load = 0, counting down:
  - Q > 0: Q ← Q-1.
  - Q = 0, SAT = 0: Q ← MODULO-1 and wrap ← 1.
  - Q = 0, SAT = 1: Q holds and wrap ← 0.
- en = 0 and load = 0: Q holds and wrap ← 0.
- tc = en & (up ? Q == MODULO-1 : Q == 0). Feed tc into the en of the next stage to cascade.
- Arithmetic: compute in WIDTH+1 bits internally so that MODULO = 2^WIDTH cannot overflow. Q never leaves the range 0..MODULO-1.
- A change of up between edges takes effect at the next edge. There is no extra state.
- Illegal parameter values stop elaboration with an error.

## Timing
- Latency from load, en, or up to Q: 1 clock edge.
- wrap is asserted in the cycle after the wrapping edge, for exactly one cycle. It repeats on every wrap when MODULO = 2 and en is held high.
- tc follows en, up and Q combinationally within the same cycle. It never glitches on CLR release because Q is already stable.
- Asserting CLR mid-count clears within the same cycle. Counting resumes at the first edge after CLR is released.
- load and a wrap condition at the same edge: load wins, wrap = 0.

## Structure
- Shared package cont_pkg holds:
  - the end-mode constants CONT_WRAP = 0 and CONT_SAT = 1;
  - a function that computes next count from (Q, up, MODULO, SAT), reused by later timer blocks.
- Single flat module. No sub-module: the next-state logic is one always block plus the tc assign.

## Test plan
- Reset: WIDTH=4, MODULO=10, INIT=3. Hold CLR=1 for 20 ns, then release -> Q=3, wrap=0, tc=0.
- Up-wrap: MODULO=10, SAT=0, en=1, up=1 from Q=0 for 12 edges -> Q runs 1..9,0,1,2. tc=1 only while Q=9. wrap=1 exactly once, in the cycle after Q returns to 0.
- Down-saturate: SAT=1, load D=2, then en=1, up=0 for 4 edges -> Q = 1, 0, 0, 0. wrap stays 0. tc=1 while Q=0.
- Load clamp and priority: MODULO=10, load=1, en=1, D=13 -> Q=9. Then load with D=5 while Q=9 and up=1 -> Q=5, wrap=0.
- Full range and cascade: two stages with WIDTH=4, MODULO=16, second stage en = tc of the first. Count 256 edges -> {Q2,Q1} goes 0x00..0xFF then back to 0x00. Second-stage wrap fires once.
- Async clear mid-count: assert CLR at Q=7, 3 ns after an edge -> Q=INIT before the next edge. wrap=0.
